fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 br_valid_in  input  1  SHALL mean that EXE has a taken branch, JAL, JALR or xRET this cycle.
REQ-005 br_pc_in  input  PC_SZ  SHALL carry the redirect target, qualified by br_valid_in.
REQ-006 trap_valid_in  input  1  SHALL mean that the CSR/trap unit requests a redirect.
REQ-007 trap_pc_in  input  PC_SZ  SHALL carry the trap vector, qualified by trap_valid_in.
REQ-008 imem_req_out  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr_out  output  PC_SZ  SHALL be the word-aligned fetch address.
REQ-010 imem_ack_in  input  1  SHALL mean the request completed; imem_rdata_in is valid in the same cycle.
REQ-011 imem_rdata_in  input  32  SHALL be the fetched instruction word.
REQ-012 fet_valid_out  output  1  SHALL mean a fetch packet is presented to decode.
REQ-013 fet_ready_in  input  1  SHALL mean decode accepts the packet.
REQ-014 fet_pc_out, fet_instr_out, fet_mis_out  output  PC_SZ/32/1  SHALL be the packet fields: address, instruction, misaligned-target flag.

Function
REQ-015 FSM states SHALL be: ST_FETCH (request outstanding), ST_FULL (packet held for decode), ST_MIS (misaligned packet held).
REQ-016 Handshake: imem_addr_out SHALL remain stable while imem_req_out=1 and imem_ack_in=0; at most one request SHALL be outstanding.
REQ-017 On ack in ST_FETCH with no kill pending, the block SHALL capture {pc, rdata}, assert fet_valid_out next cycle and enter ST_FULL; the next pc SHALL be pc+4.
REQ-018 On ack in ST_FETCH when fet_ready_in=1 and the output is empty, the block SHALL issue the pc+4 request in the cycle after ack (one bubble max).
REQ-019 ST_FULL: on fet_valid_out and fet_ready_in, the block SHALL return to ST_FETCH and assert imem_req_out in the next cycle.
REQ-020 Redirect priority: trap_valid_in SHALL win over br_valid_in when both are asserted in the same cycle.
REQ-021 On a redirect, the block SHALL deassert fet_valid_out in the next cycle (flush) and load the target into the pc.
REQ-022 A redirect while a request is un-acked SHALL set kill_pending; the matching ack data SHALL be discarded, then the target SHALL be requested in the cycle after that ack.
REQ-023 A redirect arriving in the same cycle as ack SHALL discard that ack data.
REQ-024 A redirect with target[1:0]!=0 SHALL issue no imem request; the block SHALL enter ST_MIS and present fet_valid_out=1, fet_mis_out=1, fet_pc_out=target, fet_instr_out=0.
REQ-025 ST_MIS SHALL be left only by a new redirect; a handshake in ST_MIS SHALL drop fet_valid_out and stall until the redirect.
REQ-026 A later redirect SHALL override an earlier pending one (last-wins).
REQ-027 pc+4 SHALL wrap modulo 2^PC_SZ without error.

Reset
REQ-028 During reset the block SHALL drive imem_req_out=0, fet_valid_out=0, fet_mis_out=0, fet_pc_out=0, fet_instr_out=0, kill_pending=0, pc=RESET_PC, state=ST_FETCH.
REQ-029 The first imem_req_out SHALL assert in the first clock after reset_n_in deasserts, with address RESET_PC.
REQ-030 Reset asserted mid-request SHALL drop imem_req_out asynchronously; any late ack SHALL be ignored.

Structure
REQ-031 FETCH_STATE_TYPE and the fetch-packet struct SHALL live in cpu_structs_pkg; PC_SZ SHALL come from cpu_params_pkg.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Reset with RESET_PC=0x100 and ack latency 0 -> addresses 0x100, 0x104, 0x108; packets in order.
REQ-034 br_valid_in with 0x200 while a request to 0x104 waits 3 cycles -> 0x104 data discarded, next request 0x200, no 0x104 packet.
REQ-035 trap_pc_in=0x80 and br_pc_in=0x200 in the same cycle -> next request 0x80.
REQ-036 br_pc_in=0x202 -> no imem request; packet {pc=0x202, mis=1}; held until trap to 0x80.
REQ-037 fet_ready_in held low 5 cycles in ST_FULL -> packet stable, no new request; ready high -> next request the following cycle.
REQ-038 pc=0xFFFF_FFFC (PC_SZ=32) -> next request 0x0000_0000.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Core-wide sizing parameters shared by the pipeline front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_params_pkg;

    // Width of every program-counter and fetch-address bus.
    localparam int PC_SZ = 32;

endpackage : cpu_params_pkg

// File: rtl/cpu_structs_pkg.sv
// Shared types for the fetch stage: FSM encoding and the fetch packet.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_structs_pkg;

    import cpu_params_pkg::*;

    // Fetch FSM encoding, kept as plain constants so older code can compare raw bits.
    typedef logic [1:0] FETCH_STATE_TYPE;

    localparam FETCH_STATE_TYPE ST_FETCH = 2'd0; // request outstanding / about to issue
    localparam FETCH_STATE_TYPE ST_FULL  = 2'd1; // packet held for decode
    localparam FETCH_STATE_TYPE ST_MIS   = 2'd2; // misaligned-target packet held

    // Packet handed from fetch to decode.
    typedef struct packed {
        logic [PC_SZ-1:0] pc;
        logic [31:0]      instr;
        logic             mis;
    } fet_pkt_t;

    function automatic fet_pkt_t make_pkt(input logic [PC_SZ-1:0] pc,
                                          input logic [31:0]      instr,
                                          input logic             mis);
        fet_pkt_t p;
        p.pc    = pc;
        p.instr = instr;
        p.mis   = mis;
        return p;
    endfunction

    // Sequential next fetch address; wraps modulo 2^PC_SZ by construction.
    function automatic logic [PC_SZ-1:0] pc_plus4(input logic [PC_SZ-1:0] pc);
        return pc + PC_SZ'(4);
    endfunction

endpackage : cpu_structs_pkg

// File: rtl/fetch_pc_gen.sv
// PC generator and instruction fetcher: one outstanding imem request, one packet to decode
// plus a one-entry skid. Latency: ack -> fet_valid_out next cycle; redirect -> flush next cycle.
// Backpressure: fet_ready_in low holds the packet; a prefetch that lands meanwhile goes to the
// skid and further requests stop until decode drains it.
//
// Ports:
//   clk_in, reset_n_in              clock, async active-low reset
//   br_valid_in/br_pc_in            EXE redirect (taken branch, JAL/JALR, xRET)
//   trap_valid_in/trap_pc_in        trap redirect, wins over EXE redirect
//   imem_req_out/imem_addr_out      instruction-memory request, address held until ack
//   imem_ack_in/imem_rdata_in       completion with same-cycle read data
//   fet_valid_out/fet_ready_in      packet handshake towards decode
//   fet_pc_out/fet_instr_out/fet_mis_out  packet fields
module fetch_pc_gen
    import cpu_params_pkg::*, cpu_structs_pkg::*;
#(
    parameter logic [PC_SZ-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             br_valid_in,
    input  logic [PC_SZ-1:0] br_pc_in,
    input  logic             trap_valid_in,
    input  logic [PC_SZ-1:0] trap_pc_in,
    output logic             imem_req_out,
    output logic [PC_SZ-1:0] imem_addr_out,
    input  logic             imem_ack_in,
    input  logic [31:0]      imem_rdata_in,
    output logic             fet_valid_out,
    input  logic             fet_ready_in,
    output logic [PC_SZ-1:0] fet_pc_out,
    output logic [31:0]      fet_instr_out,
    output logic             fet_mis_out
);

    FETCH_STATE_TYPE  state;
    logic [PC_SZ-1:0] pc;           // address of the current / next request
    logic [PC_SZ-1:0] kill_pc;      // target waiting for a killed request to retire
    logic             req_q;
    logic             kill_pending;
    logic             out_vld;
    fet_pkt_t         out_pkt;
    logic             skid_vld;
    fet_pkt_t         skid_pkt;

    logic             redir_vld;
    logic [PC_SZ-1:0] redir_tgt;
    logic             redir_mis;
    logic             ack_ok;
    logic             deliver;

    assign redir_vld = trap_valid_in | br_valid_in;
    assign redir_tgt = trap_valid_in ? trap_pc_in : br_pc_in;
    assign redir_mis = |redir_tgt[1:0];

    // Acks with no request in flight (e.g. a straggler from before reset) are ignored.
    assign ack_ok  = req_q & imem_ack_in;
    assign deliver = out_vld & fet_ready_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            kill_pc      <= RESET_PC;
            req_q        <= 1'b0;
            kill_pending <= 1'b0;
            out_vld      <= 1'b0;
            out_pkt      <= '0;
            skid_vld     <= 1'b0;
            skid_pkt     <= '0;
        end else if (redir_vld) begin
            // Flush whatever is queued for decode.
            skid_vld <= 1'b0;
            if (redir_mis) begin
                state   <= ST_MIS;
                out_vld <= 1'b1;
                out_pkt <= make_pkt(redir_tgt, 32'h0, 1'b1);
            end else begin
                state   <= ST_FETCH;
                out_vld <= 1'b0;
            end
            if (req_q && !imem_ack_in) begin
                // Keep the in-flight address stable; retire it, drop its data, then redirect.
                kill_pending <= 1'b1;
                kill_pc      <= redir_tgt;
            end else begin
                // Nothing in flight, or it completes right now and its data is dropped.
                kill_pending <= 1'b0;
                req_q        <= !redir_mis;
                if (!redir_mis) begin
                    pc <= redir_tgt;
                end
            end
        end else if (kill_pending) begin
            if (ack_ok) begin
                kill_pending <= 1'b0;
                if (state == ST_MIS) begin
                    req_q <= 1'b0;
                end else begin
                    req_q <= 1'b1;
                    pc    <= kill_pc;
                end
            end
            if (state == ST_MIS && deliver) begin
                out_vld <= 1'b0;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (ack_ok) begin
                        out_vld <= 1'b1;
                        out_pkt <= make_pkt(pc, imem_rdata_in, 1'b0);
                        state   <= ST_FULL;
                        pc      <= pc_plus4(pc);
                        // Prefetch only while decode looks able to keep up.
                        req_q   <= fet_ready_in;
                    end
                end
                ST_FULL: begin
                    if (ack_ok && deliver) begin
                        out_pkt <= make_pkt(pc, imem_rdata_in, 1'b0);
                        pc      <= pc_plus4(pc);
                        req_q   <= fet_ready_in;
                    end else if (ack_ok) begin
                        // Decode stalled under a prefetch: park it and stop requesting.
                        skid_vld <= 1'b1;
                        skid_pkt <= make_pkt(pc, imem_rdata_in, 1'b0);
                        pc       <= pc_plus4(pc);
                        req_q    <= 1'b0;
                    end else if (deliver) begin
                        if (skid_vld) begin
                            out_pkt  <= skid_pkt;
                            skid_vld <= 1'b0;
                        end else begin
                            out_vld <= 1'b0;
                            state   <= ST_FETCH;
                        end
                        // Either resumes fetching at pc or keeps an in-flight prefetch.
                        req_q <= 1'b1;
                    end
                end
                ST_MIS: begin
                    // Only a redirect leaves this state.
                    if (deliver) begin
                        out_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req_out  = req_q;
    assign imem_addr_out = pc;
    assign fet_valid_out = out_vld;
    assign fet_pc_out    = out_pkt.pc;
    assign fet_instr_out = out_pkt.instr;
    assign fet_mis_out   = out_pkt.mis;

endmodule : fetch_pc_gen

// File: tb/tb_fetch_pc_gen.sv
// Directed cycle-by-cycle bench for fetch_pc_gen with RESET_PC = 0x100.
// Latency: one vector per clock; outputs sampled on the falling edge.
// Backpressure: decode ready and imem ack are scripted per vector.
module tb_fetch_pc_gen;

    import cpu_params_pkg::*;

    logic             clk_in = 1'b0;
    logic             reset_n_in;
    logic             br_valid_in;
    logic [PC_SZ-1:0] br_pc_in;
    logic             trap_valid_in;
    logic [PC_SZ-1:0] trap_pc_in;
    logic             imem_req_out;
    logic [PC_SZ-1:0] imem_addr_out;
    logic             imem_ack_in;
    logic [31:0]      imem_rdata_in;
    logic             fet_valid_out;
    logic             fet_ready_in;
    logic [PC_SZ-1:0] fet_pc_out;
    logic [31:0]      fet_instr_out;
    logic             fet_mis_out;

    always #5 clk_in = ~clk_in;

    fetch_pc_gen #(.RESET_PC(32'h0000_0100)) dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .br_valid_in   (br_valid_in),
        .br_pc_in      (br_pc_in),
        .trap_valid_in (trap_valid_in),
        .trap_pc_in    (trap_pc_in),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_ack_in   (imem_ack_in),
        .imem_rdata_in (imem_rdata_in),
        .fet_valid_out (fet_valid_out),
        .fet_ready_in  (fet_ready_in),
        .fet_pc_out    (fet_pc_out),
        .fet_instr_out (fet_instr_out),
        .fet_mis_out   (fet_mis_out)
    );

    typedef struct {
        logic        br_v;
        logic [31:0] br_pc;
        logic        tr_v;
        logic [31:0] tr_pc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    function automatic vec_t v(input logic bv, input logic [31:0] bpc,
                               input logic tv, input logic [31:0] tpc,
                               input logic ack, input logic [31:0] rd, input logic rdy,
                               input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep,
                               input logic [31:0] ei, input logic em);
        vec_t r;
        r.br_v = bv;  r.br_pc = bpc; r.tr_v = tv;  r.tr_pc = tpc;
        r.ack  = ack; r.rdata = rd;  r.rdy  = rdy;
        r.e_req = er; r.e_addr = ea; r.e_vld = ev;
        r.e_pc  = ep; r.e_instr = ei; r.e_mis = em;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t x);
        chk($sformatf("v%0d imem_req", i), {31'b0, imem_req_out}, {31'b0, x.e_req});
        if (x.e_req)
            chk($sformatf("v%0d imem_addr", i), imem_addr_out, x.e_addr);
        chk($sformatf("v%0d fet_valid", i), {31'b0, fet_valid_out}, {31'b0, x.e_vld});
        if (x.e_vld) begin
            chk($sformatf("v%0d fet_pc", i), fet_pc_out, x.e_pc);
            chk($sformatf("v%0d fet_instr", i), fet_instr_out, x.e_instr);
            chk($sformatf("v%0d fet_mis", i), {31'b0, fet_mis_out}, {31'b0, x.e_mis});
        end
    endtask

    task automatic drive_vec(input vec_t x);
        br_valid_in   = x.br_v;
        br_pc_in      = x.br_pc;
        trap_valid_in = x.tr_v;
        trap_pc_in    = x.tr_pc;
        imem_ack_in   = x.ack;
        imem_rdata_in = x.rdata;
        fet_ready_in  = x.rdy;
    endtask

    initial begin
        //                 br  br_pc         tr  tr_pc  ack rdata         rdy  req addr          vld pc            instr         mis
        // reset release, first request, streaming with zero-latency acks
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   0, 0,            0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0100, 1,   1, 32'h100,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0104, 1,   1, 32'h104,      1, 32'h100,      32'hC0DE0100, 0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0108, 1,   1, 32'h108,      1, 32'h104,      32'hC0DE0104, 0));
        // decode stalls 5 cycles; the in-flight prefetch lands in the skid
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE010C, 0,   1, 32'h10C,      1, 32'h108,      32'hC0DE0108, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(0, 0,        0, 0,     0, 0,            0,   0, 0,            1, 32'h108,      32'hC0DE0108, 0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   0, 0,            1, 32'h108,      32'hC0DE0108, 0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   1, 32'h110,      1, 32'h10C,      32'hC0DE010C, 0));
        // branch to 0x200 while 0x110 waits three cycles; its data is dropped
        vecs.push_back(v(1, 32'h200,      0, 0,     0, 0,            1,   1, 32'h110,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   1, 32'h110,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, DEAD,         1,   1, 32'h110,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0200, 1,   1, 32'h200,      0, 0,            0,            0));
        // trap and branch together, coinciding with an ack that must be dropped
        vecs.push_back(v(1, 32'h200,      1, 32'h80, 1, DEAD,        1,   1, 32'h204,      1, 32'h200,      32'hC0DE0200, 0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0080, 0,   1, 32'h080,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            0,   0, 0,            1, 32'h080,      32'hC0DE0080, 0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   0, 0,            1, 32'h080,      32'hC0DE0080, 0));
        // misaligned branch target while 0x84 is in flight
        vecs.push_back(v(1, 32'h202,      0, 0,     0, 0,            1,   1, 32'h084,      0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, DEAD,         0,   1, 32'h084,      1, 32'h202,      0,            1));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   0, 0,            1, 32'h202,      0,            1));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            1,   0, 0,            0, 0,            0,            0));
        vecs.push_back(v(0, 0,            1, 32'h80, 0, 0,           1,   0, 0,            0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0080, 1,   1, 32'h080,      0, 0,            0,            0));
        // wrap at the top of the address space
        vecs.push_back(v(1, 32'hFFFFFFFC, 0, 0,     1, DEAD,         1,   1, 32'h084,      1, 32'h080,      32'hC0DE0080, 0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DEFFFC, 1,   1, 32'hFFFFFFFC, 0, 0,            0,            0));
        vecs.push_back(v(0, 0,            0, 0,     1, 32'hC0DE0000, 1,   1, 32'h000,      1, 32'hFFFFFFFC, 32'hC0DEFFFC, 0));
        vecs.push_back(v(0, 0,            0, 0,     0, 0,            0,   1, 32'h004,      1, 32'h000,      32'hC0DE0000, 0));

        reset_n_in    = 1'b0;
        br_valid_in   = 1'b0;
        br_pc_in      = '0;
        trap_valid_in = 1'b0;
        trap_pc_in    = '0;
        imem_ack_in   = 1'b0;
        imem_rdata_in = '0;
        fet_ready_in  = 1'b1;

        repeat (2) @(negedge clk_in);
        chk("reset imem_req",  {31'b0, imem_req_out},  32'h0);
        chk("reset fet_valid", {31'b0, fet_valid_out}, 32'h0);
        chk("reset fet_mis",   {31'b0, fet_mis_out},   32'h0);
        chk("reset fet_pc",    fet_pc_out,             32'h0);
        chk("reset fet_instr", fet_instr_out,          32'h0);
        reset_n_in = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk_in);
            check_vec(i, vecs[i]);
            drive_vec(vecs[i]);
        end

        // Reset in the middle of an outstanding request, then a stale ack after release.
        @(negedge clk_in);
        chk("pre-reset imem_req", {31'b0, imem_req_out}, 32'h1);
        #2 reset_n_in = 1'b0;
        #1;
        chk("async reset imem_req",  {31'b0, imem_req_out},  32'h0);
        chk("async reset fet_valid", {31'b0, fet_valid_out}, 32'h0);
        @(negedge clk_in);
        reset_n_in    = 1'b1;
        imem_ack_in   = 1'b1;
        imem_rdata_in = DEAD;
        fet_ready_in  = 1'b1;
        @(negedge clk_in);
        chk("re-reset imem_req",  {31'b0, imem_req_out},  32'h1);
        chk("re-reset imem_addr", imem_addr_out,          32'h100);
        chk("re-reset fet_valid", {31'b0, fet_valid_out}, 32'h0);
        imem_ack_in = 1'b0;
        @(negedge clk_in);
        chk("held imem_req",  {31'b0, imem_req_out},  32'h1);
        chk("held imem_addr", imem_addr_out,          32'h100);
        chk("stale ack fet_valid", {31'b0, fet_valid_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_pc_gen
